controlador_entrada: RTL

//  Input stage feeding the processor's IN path: synchronises and debounces the switches and the confirm button.

---
 rtl/controlador_entrada_pkg.sv | 17 +
 rtl/controlador_entrada_if.sv | 24 ++
 rtl/controlador_entrada_sincronizador.sv | 26 ++
 rtl/controlador_entrada.sv | 110 +++++++++++
 4 files changed

// File: rtl/controlador_entrada_pkg.sv
// Shared definitions for the processor input stage.
// Holds the FSM state encoding and a small status decode helper.
package controlador_entrada_pkg;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_BOTAO  = 3'd1,
        FILTRO        = 3'd2,
        PRONTO        = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

    function automatic logic eh_aguardando(estado_t e);
        return (e == ESPERA_BOTAO) || (e == FILTRO);
    endfunction

endpackage

// File: rtl/controlador_entrada_if.sv
// Signal bundle between the board/control unit and the input stage.
// master: drives chaves, botao_n, in_req. slave: drives entrada, check, aguardando, num_entradas.
interface controlador_entrada_if #(
    parameter int LARGURA   = 4,
    parameter int LARG_CONT = 8
);
    logic [LARGURA-1:0]   chaves;
    logic                 botao_n;
    logic                 in_req;
    logic [LARGURA-1:0]   entrada;
    logic                 check;
    logic                 aguardando;
    logic [LARG_CONT-1:0] num_entradas;

    modport master (
        output chaves, botao_n, in_req,
        input  entrada, check, aguardando, num_entradas
    );

    modport slave (
        input  chaves, botao_n, in_req,
        output entrada, check, aguardando, num_entradas
    );
endinterface

// File: rtl/controlador_entrada_sincronizador.sv
// Two-flop synchroniser for asynchronous board inputs.
// Ports: clock, reset (async active-low), d (raw), q (synchronised); RESET_VAL sets the idle level.
module sincronizador #(
    parameter int                 LARGURA   = 1,
    parameter logic [LARGURA-1:0] RESET_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);
    logic [LARGURA-1:0] s1_q;
    logic [LARGURA-1:0] s2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/controlador_entrada.sv
// Input stage: syncs/debounces switches and confirm button, captures entrada, pulses check once per press.
// Ports: clock, reset (async active-low), io (slave side of controlador_entrada_if).
module controlador_entrada
    import controlador_entrada_pkg::*;
#(
    parameter int LARGURA       = 4,
    parameter int CICLOS_FILTRO = 4,
    parameter int LARG_CONT     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    controlador_entrada_if.slave  io
);
    localparam int CW = $clog2(CICLOS_FILTRO + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_FILTRO - 1);

    logic [LARGURA-1:0] chaves_sync;
    logic               botao_sync;
    logic               p;

    sincronizador #(.LARGURA(LARGURA), .RESET_VAL('0)) u_sync_chaves (
        .clock (clock),
        .reset (reset),
        .d     (io.chaves),
        .q     (chaves_sync)
    );

    sincronizador #(.LARGURA(1), .RESET_VAL(1'b1)) u_sync_botao (
        .clock (clock),
        .reset (reset),
        .d     (io.botao_n),
        .q     (botao_sync)
    );

    assign p = ~botao_sync;

    estado_t              state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LARGURA-1:0]   entrada_q, entrada_d;
    logic [LARG_CONT-1:0] num_q, num_d;
    logic                 check_q, check_d;
    logic                 aguardando_q, aguardando_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= OCIOSO;
            cnt_q        <= '0;
            entrada_q    <= '0;
            num_q        <= '0;
            check_q      <= 1'b0;
            aguardando_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            entrada_q    <= entrada_d;
            num_q        <= num_d;
            check_q      <= check_d;
            aguardando_q <= aguardando_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        entrada_d = entrada_q;
        num_d     = num_q;
        case (state_q)
            OCIOSO: begin
                if (io.in_req) state_d = ESPERA_BOTAO;
            end
            ESPERA_BOTAO: begin
                if (!io.in_req) begin
                    state_d = OCIOSO;
                end else if (p) begin
                    state_d = FILTRO;
                    cnt_d   = '0;
                end
            end
            FILTRO: begin
                if (!io.in_req) begin
                    state_d = OCIOSO;
                end else if (!p) begin
                    state_d = ESPERA_BOTAO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = PRONTO;
                    entrada_d = chaves_sync;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRONTO: begin
                state_d = ESPERA_SOLTAR;
                num_d   = num_q + 1'b1;
            end
            ESPERA_SOLTAR: begin
                // a held button must be released before the next IN can be confirmed
                if (!p) state_d = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
        // outputs registered from the next state so they align with state_q
        check_d      = (state_d == PRONTO);
        aguardando_d = eh_aguardando(state_d);
    end

    assign io.entrada      = entrada_q;
    assign io.check        = check_q;
    assign io.aguardando   = aguardando_q;
    assign io.num_entradas = num_q;
endmodule
